// File: rtl/btn_cmd_arbiter_pkg.sv
// Shared types and constants for the button command arbiter.
// State encoding, default debounce timing and a constant log2 helper.
package btn_cmd_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_TICK_DIV = 100000;
    localparam int DEF_SAMPLES  = 16;

    // Ceiling log2; gives 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, SAMPLES-tick debounce, rising-edge press pulse.
// press is combinational from registered state, high one cycle when the debounced level rises; no backpressure.
module btn_debounce_ch
    import btn_cmd_arbiter_pkg::*;
#(
    parameter int SAMPLES = DEF_SAMPLES
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_raw,
    output logic press
);

    logic               sync_q1;
    logic               sync_q2;
    logic [SAMPLES-1:0] shift_q;
    logic               stable;
    logic               stable_d;

    // A single low sample anywhere in the window breaks the run.
    assign stable = &shift_q;
    assign press  = stable & ~stable_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            shift_q  <= '0;
            stable_d <= 1'b0;
        end else begin
            sync_q1  <= btn_raw;
            sync_q2  <= sync_q1;
            stable_d <= stable;
            if (tick) begin
                shift_q <= {shift_q[SAMPLES-2:0], sync_q2};
            end
        end
    end

endmodule

// File: rtl/btn_cmd_arbiter.sv
// Debounced button presses become pending commands, granted round-robin on one valid/ack port.
// Press->pending 1 cycle, ->cmd_valid 2 cycles; cmd_valid/cmd_id hold until cmd_ack, then idle one cycle.
module btn_cmd_arbiter
    import btn_cmd_arbiter_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int SAMPLES  = DEF_SAMPLES,
    parameter int ID_W     = clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn_raw,
    input  logic              cmd_ack,
    output logic              cmd_valid,
    output logic [ID_W-1:0]   cmd_id,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] overrun
);

    localparam int CNT_W = clog2(TICK_DIV);

    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic [NUM_CH-1:0] press;
    logic [NUM_CH-1:0] clr;
    logic [ID_W-1:0]   last;
    logic [ID_W-1:0]   rr_sel;
    logic              rr_hit;
    int                rr_idx;
    arb_state_t        state;

    assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        btn_debounce_ch #(
            .SAMPLES (SAMPLES)
        ) u_deb (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .btn_raw (btn_raw[g]),
            .press   (press[g])
        );
    end

    always_comb begin
        clr = '0;
        if (state == ST_GRANT && cmd_ack) begin
            clr[cmd_id] = 1'b1;
        end
    end

    // A press in the same cycle as its own clear keeps the command pending and is not an overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= press | (pending & ~clr);
            overrun <= overrun | (press & pending & ~clr);
        end
    end

    // Search starts just after the last granted channel and wraps.
    always_comb begin
        rr_sel = '0;
        rr_hit = 1'b0;
        rr_idx = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            rr_idx = int'(last) + k;
            if (rr_idx >= NUM_CH) begin
                rr_idx = rr_idx - NUM_CH;
            end
            if (!rr_hit && pending[rr_idx]) begin
                rr_sel = ID_W'(rr_idx);
                rr_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cmd_valid <= 1'b0;
            cmd_id    <= '0;
            last      <= ID_W'(NUM_CH - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rr_hit) begin
                        cmd_id    <= rr_sel;
                        cmd_valid <= 1'b1;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (cmd_ack) begin
                        last      <= cmd_id;
                        cmd_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    cmd_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
